ball_motion: RTL and testbench

- Parametrised successor to the single-step ball mover.
- Owns ball position, direction and speed, and advances the ball once per video frame.
- Bounces the ball off the top and bottom walls and off paddles (driven by paddle-hit inputs); detects goals and runs a serve/re-serve sequence.
- Sits between the game controller (codewords, paddle hits) and the pixel generator (ball centre).

---
 rtl/pong_pkg.sv | 52 +++++
 rtl/ball_motion_if.sv | 28 ++
 rtl/ball_axis.sv | 52 +++++
 rtl/ball_motion.sv | 143 ++++++++++++++
 tb/tb_ball_motion.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pong_pkg.sv
// Shared definitions for the ball motion block: codewords, FSM states,
// default field geometry and small decode helpers.
package pong_pkg;

  localparam logic [3:0] CW_DR    = 4'b0001;
  localparam logic [3:0] CW_UL    = 4'b0010;
  localparam logic [3:0] CW_DL    = 4'b0011;
  localparam logic [3:0] CW_UR    = 4'b0100;
  localparam logic [3:0] CW_SERVE = 4'b0101;

  typedef enum logic [1:0] {
    SERVE,
    MOVE,
    SCORED
  } state_t;

  localparam int H_RES_DEF       = 640;
  localparam int V_RES_DEF       = 480;
  localparam int BALL_R_DEF      = 4;
  localparam int START_X_DEF     = 320;
  localparam int START_Y_DEF     = 220;
  localparam int MAX_SPEED_DEF   = 4;
  localparam int SERVE_DELAY_DEF = 60;
  localparam int W_DEF           = 10;

  // dx = 1 means moving left, dy = 1 means moving up.
  typedef struct packed {
    logic valid;
    logic dx;
    logic dy;
  } dir_cmd_t;

  function automatic dir_cmd_t decode_dir(input logic [3:0] cmd);
    dir_cmd_t d;
    d = '0;
    case (cmd)
      CW_UL:   begin d.valid = 1'b1; d.dx = 1'b1; d.dy = 1'b1; end
      CW_DL:   begin d.valid = 1'b1; d.dx = 1'b1; d.dy = 1'b0; end
      CW_UR:   begin d.valid = 1'b1; d.dx = 1'b0; d.dy = 1'b1; end
      CW_DR:   begin d.valid = 1'b1; d.dx = 1'b0; d.dy = 1'b0; end
      default: d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [2:0] clamp_speed(input logic [2:0] req, input int max_speed);
    if (req == 3'd0) return 3'd1;
    if (int'(req) > max_speed) return 3'(max_speed);
    return req;
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Controller-side bundle of the ball motion block: frame/command inputs
// from the game controller and the ball state seen by the pixel generator.
interface ball_motion_if #(
  parameter int W = 10
);
  logic         frame_tick;
  logic [3:0]   cmd;
  logic [2:0]   speed;
  logic         hit_left;
  logic         hit_right;
  logic [W-1:0] ball_center_x;
  logic [W-1:0] ball_center_y;
  logic         dir_x;
  logic         dir_y;
  logic         goal_left;
  logic         goal_right;
  logic         serving;

  modport master (
    output frame_tick, cmd, speed, hit_left, hit_right,
    input  ball_center_x, ball_center_y, dir_x, dir_y, goal_left, goal_right, serving
  );

  modport slave (
    input  frame_tick, cmd, speed, hit_left, hit_right,
    output ball_center_x, ball_center_y, dir_x, dir_y, goal_left, goal_right, serving
  );
endinterface

// File: rtl/ball_axis.sv
// One axis of ball motion: steps the position by s toward the low (dir=1)
// or high (dir=0) edge, clamping and reversing when the edge is reached.
module ball_axis #(
  parameter int RES    = 640,
  parameter int BALL_R = 4,
  parameter int W      = 10
) (
  input  logic [W-1:0] pos,
  input  logic         dir,
  input  logic [W:0]   s,
  input  logic         enable,
  output logic [W-1:0] next_pos,
  output logic         next_dir,
  output logic         edge_hit
);
  localparam int WE = W + 1;
  localparam logic [W:0]   MIN_E   = WE'(BALL_R);
  localparam logic [W:0]   MAX_E   = WE'(RES - 1 - BALL_R);
  localparam logic [W-1:0] MIN_POS = W'(BALL_R);
  localparam logic [W-1:0] MAX_POS = W'(RES - 1 - BALL_R);

  logic [W:0] pos_e;
  assign pos_e = {1'b0, pos};

  always_comb begin
    // NOTE: every output gets a default before any branch, so no path can leave one unassigned and infer a latch.
    next_pos = pos;
    next_dir = dir;
    edge_hit = 1'b0;
    if (enable) begin
      // Compare against BALL_R+s rather than subtracting first, so nothing wraps.
      if (dir) begin
        if (pos_e < MIN_E + s) begin
          next_pos = MIN_POS;
          next_dir = 1'b0;
          edge_hit = 1'b1;
        end else begin
          next_pos = W'(pos_e - s);
        end
      end else begin
        if (pos_e + s > MAX_E) begin
          next_pos = MAX_POS;
          next_dir = 1'b1;
          edge_hit = 1'b1;
        end else begin
          next_pos = W'(pos_e + s);
        end
      end
    end
  end

endmodule

// File: rtl/ball_motion.sv
// Ball position/direction/speed owner: serves, steps once per frame_tick,
// bounces off walls and paddles, and pulses a goal when the ball exits.
module ball_motion
  import pong_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int V_RES       = V_RES_DEF,
  parameter int BALL_R      = BALL_R_DEF,
  parameter int START_X     = START_X_DEF,
  parameter int START_Y     = START_Y_DEF,
  parameter int MAX_SPEED   = MAX_SPEED_DEF,
  parameter int SERVE_DELAY = SERVE_DELAY_DEF,
  parameter int W           = W_DEF
) (
  input logic          clk,
  input logic          reset_n,
  ball_motion_if.slave bus
);
  localparam int WE    = W + 1;
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam logic [W-1:0]     X0       = W'(START_X);
  localparam logic [W-1:0]     Y0       = W'(START_Y);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  state_t           state, state_nx;
  logic [W-1:0]     x, x_nx, y, y_nx;
  logic             dx, dx_nx, dy, dy_nx;
  logic             gl, gl_nx, gr, gr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;

  dir_cmd_t     dcmd;
  logic         eff_dx, eff_dy, step;
  logic [W:0]   s;
  logic [W-1:0] ax_pos, ay_pos;
  logic         ax_dir, ay_dir, ax_edge, ay_edge;

  // A direction command in the same cycle as a tick steers that tick's step.
  assign dcmd   = decode_dir(bus.cmd);
  assign eff_dx = dcmd.valid ? dcmd.dx : dx;
  assign eff_dy = dcmd.valid ? dcmd.dy : dy;
  assign s      = WE'(clamp_speed(bus.speed, MAX_SPEED));
  assign step   = bus.frame_tick && (state == MOVE);

  ball_axis #(.RES(H_RES), .BALL_R(BALL_R), .W(W)) u_axis_x (
    .pos(x), .dir(eff_dx), .s(s), .enable(step),
    .next_pos(ax_pos), .next_dir(ax_dir), .edge_hit(ax_edge)
  );

  ball_axis #(.RES(V_RES), .BALL_R(BALL_R), .W(W)) u_axis_y (
    .pos(y), .dir(eff_dy), .s(s), .enable(step),
    .next_pos(ay_pos), .next_dir(ay_dir), .edge_hit(ay_edge)
  );

  always_comb begin
    state_nx = state;
    x_nx     = x;
    y_nx     = y;
    dx_nx    = eff_dx;
    dy_nx    = eff_dy;
    cnt_nx   = cnt;
    gl_nx    = 1'b0;
    gr_nx    = 1'b0;
    if (bus.cmd == CW_SERVE) begin
      state_nx = SERVE;
      x_nx     = X0;
      y_nx     = Y0;
      cnt_nx   = '0;
    end else begin
      case (state)
        SERVE: begin
          if (bus.frame_tick) begin
            if (cnt == CNT_LAST) begin
              state_nx = MOVE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        MOVE: begin
          if (bus.frame_tick) begin
            y_nx  = ay_pos;
            dy_nx = ay_edge ? ay_dir : eff_dy;
            // Paddle returns take precedence over the field edge.
            if (eff_dx && bus.hit_left) begin
              x_nx  = W'({1'b0, x} + s);
              dx_nx = 1'b0;
            end else if (!eff_dx && bus.hit_right) begin
              x_nx  = W'({1'b0, x} - s);
              dx_nx = 1'b1;
            end else begin
              x_nx  = ax_pos;
              dx_nx = ax_dir;
              if (ax_edge) begin
                state_nx = SCORED;
                gr_nx    = eff_dx;
                gl_nx    = !eff_dx;
              end
            end
          end
        end
        default: begin
          state_nx = SERVE;
          x_nx     = X0;
          y_nx     = Y0;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    if (!reset_n) begin
      state <= SERVE;
      x     <= X0;
      y     <= Y0;
      dx    <= 1'b0;
      dy    <= 1'b0;
      cnt   <= '0;
      gl    <= 1'b0;
      gr    <= 1'b0;
    end else begin
      state <= state_nx;
      x     <= x_nx;
      y     <= y_nx;
      dx    <= dx_nx;
      dy    <= dy_nx;
      cnt   <= cnt_nx;
      gl    <= gl_nx;
      gr    <= gr_nx;
    end
  end

  assign bus.ball_center_x = x;
  assign bus.ball_center_y = y;
  assign bus.dir_x         = dx;
  assign bus.dir_y         = dy;
  assign bus.goal_left     = gl;
  assign bus.goal_right    = gr;
  assign bus.serving       = (state == SERVE);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: directed scenarios followed by random
// frames, all compared every cycle against a plain-arithmetic game model.
module tb_ball_motion;
  import pong_pkg::*;

  localparam int H_RES = 640, V_RES = 480, BALL_R = 4;
  localparam int START_X = 320, START_Y = 220;
  localparam int MAX_SPEED = 4, SERVE_DELAY = 60, W = 10;
  localparam int M_SERVE = 0, M_MOVE = 1, M_SCORED = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  ball_motion_if #(.W(W)) bus ();

  ball_motion #(
    .H_RES(H_RES), .V_RES(V_RES), .BALL_R(BALL_R), .START_X(START_X),
    .START_Y(START_Y), .MAX_SPEED(MAX_SPEED), .SERVE_DELAY(SERVE_DELAY), .W(W)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference game state
  int m_x, m_y, m_dx, m_dy, m_mode, m_cnt, m_gl, m_gr;

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_tests++;
    if (got !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sclamp(input int sp);
    if (sp == 0) return 1;
    if (sp > MAX_SPEED) return MAX_SPEED;
    return sp;
  endfunction

  task automatic recentre();
    m_x = START_X;
    m_y = START_Y;
    m_mode = M_SERVE;
    m_cnt = 0;
  endtask

  // What the next clock edge should produce, given this cycle's inputs.
  task automatic model_step(input bit rst_lo, input bit tick, input int cmd,
                            input int sp, input bit hl, input bit hr);
    int s, ny, nx;
    m_gl = 0;
    m_gr = 0;
    if (rst_lo) begin
      recentre();
      m_dx = 0;
      m_dy = 0;
      return;
    end
    if (cmd == 5) begin
      recentre();
      return;
    end
    case (cmd)
      2: begin m_dx = 1; m_dy = 1; end
      3: begin m_dx = 1; m_dy = 0; end
      4: begin m_dx = 0; m_dy = 1; end
      1: begin m_dx = 0; m_dy = 0; end
      default: ;
    endcase
    if (m_mode == M_SCORED) begin
      recentre();
      return;
    end
    if (!tick) return;
    if (m_mode == M_SERVE) begin
      m_cnt++;
      if (m_cnt == SERVE_DELAY) begin
        m_mode = M_MOVE;
        m_cnt = 0;
      end
      return;
    end
    s = sclamp(sp);
    ny = m_dy ? m_y - s : m_y + s;
    if (ny < BALL_R) begin
      ny = BALL_R;
      m_dy = 0;
    end else if (ny > V_RES - 1 - BALL_R) begin
      ny = V_RES - 1 - BALL_R;
      m_dy = 1;
    end
    m_y = ny;
    if (m_dx == 1 && hl) begin
      m_x = m_x + s;
      m_dx = 0;
    end else if (m_dx == 0 && hr) begin
      m_x = m_x - s;
      m_dx = 1;
    end else begin
      nx = m_dx ? m_x - s : m_x + s;
      if (nx < BALL_R) begin
        m_x = BALL_R;
        m_gr = 1;
        m_dx = 0;
        m_mode = M_SCORED;
      end else if (nx > H_RES - 1 - BALL_R) begin
        m_x = H_RES - 1 - BALL_R;
        m_gl = 1;
        m_dx = 1;
        m_mode = M_SCORED;
      end else begin
        m_x = nx;
      end
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, "/x"}, 32'(bus.ball_center_x), m_x);
    check({tag, "/y"}, 32'(bus.ball_center_y), m_y);
    check({tag, "/dir_x"}, 32'(bus.dir_x), m_dx);
    check({tag, "/dir_y"}, 32'(bus.dir_y), m_dy);
    check({tag, "/goal_left"}, 32'(bus.goal_left), m_gl);
    check({tag, "/goal_right"}, 32'(bus.goal_right), m_gr);
    check({tag, "/serving"}, 32'(bus.serving), (m_mode == M_SERVE) ? 1 : 0);
    check({tag, "/goal_excl"}, 32'(bus.goal_left & bus.goal_right), 0);
  endtask

  task automatic cyc(input string tag, input bit tick, input logic [3:0] cmd,
                     input int sp, input bit hl, input bit hr);
    bus.frame_tick = tick;
    bus.cmd        = cmd;
    bus.speed      = 3'(sp);
    bus.hit_left   = hl;
    bus.hit_right  = hr;
    model_step(!reset_n, tick, int'(cmd), sp, hl, hr);
    @(posedge clk);
    #1;
    compare_all(tag);
    bus.frame_tick = 1'b0;
    bus.cmd        = 4'd0;
    bus.hit_left   = 1'b0;
    bus.hit_right  = 1'b0;
  endtask

  task automatic serve_wait();
    for (int i = 1; i <= SERVE_DELAY; i++) begin
      cyc("serve", 1'b1, 4'd0, 1, 1'b0, 1'b0);
      if (i == SERVE_DELAY - 1) check("serve_hold", 32'(bus.serving), 1);
      if (i == SERVE_DELAY)     check("serve_end", 32'(bus.serving), 0);
    end
  endtask

  initial begin
    bus.frame_tick = 1'b0;
    bus.cmd        = 4'd0;
    bus.speed      = 3'd1;
    bus.hit_left   = 1'b0;
    bus.hit_right  = 1'b0;
    m_dx = 0; m_dy = 0; m_gl = 0; m_gr = 0;
    recentre();

    // Reset state
    reset_n = 1'b0;
    cyc("reset", 1'b0, 4'd0, 1, 1'b0, 1'b0);
    check("rst_x", 32'(bus.ball_center_x), 320);
    check("rst_y", 32'(bus.ball_center_y), 220);
    check("rst_serving", 32'(bus.serving), 1);
    reset_n = 1'b1;

    // Serve timing and first move
    serve_wait();
    check("serve_x", 32'(bus.ball_center_x), 320);
    check("serve_y", 32'(bus.ball_center_y), 220);
    cyc("first_move", 1'b1, CW_DR, 1, 1'b0, 1'b0);
    check("first_x", 32'(bus.ball_center_x), 321);
    check("first_y", 32'(bus.ball_center_y), 221);

    // Top wall bounce
    cyc("wall", 1'b1, CW_UR, 3, 1'b0, 1'b0);
    for (int k = 0; k < 53; k++) cyc("wall", 1'b1, 4'd0, 4, 1'b0, 1'b0);
    check("wall_pre_y", 32'(bus.ball_center_y), 6);
    cyc("wall", 1'b1, 4'd0, 4, 1'b0, 1'b0);
    check("wall_y", 32'(bus.ball_center_y), 4);
    check("wall_dir_y", 32'(bus.dir_y), 0);
    cyc("wall", 1'b1, 4'd0, 4, 1'b0, 1'b0);
    check("wall_post_y", 32'(bus.ball_center_y), 8);
    check("wall_post_x", 32'(bus.ball_center_x), 544);

    // Paddle hits
    cyc("paddle", 1'b1, CW_UL, 4, 1'b0, 1'b0);
    for (int k = 0; k < 110; k++) cyc("paddle", 1'b1, 4'd0, 4, 1'b0, 1'b0);
    check("paddle_pre_x", 32'(bus.ball_center_x), 100);
    cyc("paddle", 1'b1, 4'd0, 2, 1'b1, 1'b0);
    check("hit_left_x", 32'(bus.ball_center_x), 102);
    check("hit_left_dir", 32'(bus.dir_x), 0);
    cyc("paddle", 1'b1, CW_UL, 2, 1'b0, 1'b1);
    check("hit_ignored_x", 32'(bus.ball_center_x), 100);
    check("hit_ignored_dir", 32'(bus.dir_x), 1);
    cyc("paddle", 1'b1, CW_UR, 2, 1'b0, 1'b1);
    check("hit_right_x", 32'(bus.ball_center_x), 98);
    check("hit_right_dir", 32'(bus.dir_x), 1);

    // Goal on the left edge
    for (int k = 0; k < 31; k++) cyc("goal", 1'b1, 4'd0, 3, 1'b0, 1'b0);
    check("goal_pre_x", 32'(bus.ball_center_x), 5);
    cyc("goal", 1'b1, 4'd0, 3, 1'b0, 1'b0);
    check("goal_x", 32'(bus.ball_center_x), 4);
    check("goal_right_hi", 32'(bus.goal_right), 1);
    check("goal_left_lo", 32'(bus.goal_left), 0);
    cyc("goal", 1'b0, 4'd0, 3, 1'b0, 1'b0);
    check("goal_right_gone", 32'(bus.goal_right), 0);
    check("goal_recentre_x", 32'(bus.ball_center_x), 320);
    check("goal_recentre_y", 32'(bus.ball_center_y), 220);
    check("goal_serving", 32'(bus.serving), 1);
    check("goal_dir_x", 32'(bus.dir_x), 0);

    // Recentre command beats a tick during MOVE and restarts the serve count
    serve_wait();
    cyc("ovr", 1'b1, CW_DR, 1, 1'b0, 1'b0);
    cyc("ovr", 1'b1, 4'd0, 1, 1'b0, 1'b0);
    cyc("ovr", 1'b1, CW_SERVE, 4, 1'b0, 1'b0);
    check("ovr_x", 32'(bus.ball_center_x), 320);
    check("ovr_y", 32'(bus.ball_center_y), 220);
    check("ovr_serving", 32'(bus.serving), 1);
    serve_wait();

    // Speed clamp and reset during MOVE
    cyc("speed", 1'b1, CW_DR, 0, 1'b0, 1'b0);
    check("speed0_x", 32'(bus.ball_center_x), 321);
    cyc("speed", 1'b1, 4'd0, 7, 1'b0, 1'b0);
    check("speed7_x", 32'(bus.ball_center_x), 325);
    check("speed7_y", 32'(bus.ball_center_y), 225);
    reset_n = 1'b0;
    cyc("mid_reset", 1'b1, 4'd0, 4, 1'b0, 1'b0);
    check("mid_reset_x", 32'(bus.ball_center_x), 320);
    check("mid_reset_serving", 32'(bus.serving), 1);
    reset_n = 1'b1;

    // Random play
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [3:0] c;
      bit t, hl, hr;
      r = $urandom_range(0, 999);
      if (r < 2)        c = CW_SERVE;
      else if (r < 80)  c = 4'($urandom_range(1, 4));
      else if (r < 100) c = 4'($urandom_range(6, 15));
      else              c = 4'd0;
      t  = 1'($urandom_range(0, 1));
      hl = 1'b0;
      hr = 1'b0;
      if (m_x >= BALL_R + MAX_SPEED && m_x <= H_RES - 1 - BALL_R - MAX_SPEED) begin
        hl = ($urandom_range(0, 9) == 0);
        hr = ($urandom_range(0, 9) == 0);
      end
      reset_n = ($urandom_range(0, 1999) != 0);
      cyc("rand", t, c, int'($urandom_range(0, 7)), hl, hr);
      reset_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
